slice_config_loader: RTL and testbench

- Upstream configuration stage for the fractured-LUT logic slice.
- Accepts a byte-stream configuration image over a valid/ready handshake and assembles the full slice image in a shadow register.
- Drives every per-LUT configuration bus and the carry-chain select, then pulses the configuration enable for exactly one cycle so the slice latches a stable, complete image.
- One instance per slice, daisy-chainable by the bitstream controller.

---
 rtl/slice_cfg_pkg.sv | 41 ++++
 rtl/cfg_crc8.sv | 26 ++
 rtl/slice_config_loader.sv | 172 +++++++++++++++++
 tb/tb_slice_config_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_cfg_pkg.sv
// Shared types, derivation helpers and CRC-8 step for the slice configuration loader.
// The CRC datapath is only built when SLICE_CONFIG_LOADER_CRC_EN is defined.
package slice_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int lut_cfg_w(input int l_mem);
    return 2 * l_mem;
  endfunction

  function automatic int img_w(input int nluts, input int lutw);
    return nluts * lutw + 1;
  endfunction

  function automatic int nwords(input int imgw, input int cfgw);
    return (imgw + cfgw - 1) / cfgw;
  endfunction

  // MSB-first CRC-8 update over one byte
  function automatic logic [7:0] crc8_byte(
    input logic [7:0] crc,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Byte-serial CRC-8 accumulator with synchronous clear and enable.
// Instantiated by slice_config_loader when SLICE_CONFIG_LOADER_CRC_EN is defined.
module cfg_crc8
  import slice_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc8_byte(crc_q, data);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/slice_config_loader.sv
// Streams a byte image into a shadow register and commits it to the slice.
// Optional CRC-8 check of the image is enabled by SLICE_CONFIG_LOADER_CRC_EN.
module slice_config_loader
  import slice_cfg_pkg::*;
#(
  parameter int S_XX_BASE  = 4,
  parameter int L_MEM_SIZE = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS   = 4,
  parameter int CFG_W      = 8,
  localparam int LUT_CFG_W = lut_cfg_w(L_MEM_SIZE),
  localparam int IMG_W     = img_w(NUM_LUTS, LUT_CFG_W),
  localparam int NWORDS    = nwords(IMG_W, CFG_W)
) (
  input  logic                          config_clk,
  input  logic                          config_rst,
  input  logic                          cfg_start,
  input  logic [CFG_W-1:0]              cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic [NUM_LUTS*LUT_CFG_W-1:0] luts_config_out,
  output logic                          config_use_cc,
  output logic                          config_en,
  output logic                          cfg_done,
  output logic                          cfg_error
);

  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_cc_q, use_cc_d;
  logic             done_q, done_d;
  logic             en_q;
  logic             ready_q;
  logic             xfer;

  assign xfer = cfg_valid && ready_q;

`ifdef SLICE_CONFIG_LOADER_CRC_EN
  if (CFG_W != 8) begin : g_bad_cfg_w
    $error("CRC-8 check needs CFG_W == 8");
  end

  logic       err_q, err_d;
  logic       crc_en;
  logic [7:0] crc;

  assign crc_en = xfer && (state_q == LOAD) && !cfg_start;

  cfg_crc8 u_crc (
    .clk  (config_clk),
    .rst  (config_rst),
    .clr  (cfg_start),
    .en   (crc_en),
    .data (cfg_data[7:0]),
    .crc  (crc)
  );

  assign cfg_error = err_q;
`else
  assign cfg_error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    cnt_d    = cnt_q;
    use_cc_d = use_cc_q;
    done_d   = done_q;
`ifdef SLICE_CONFIG_LOADER_CRC_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (xfer) begin
          // padding bits past the image in the last word fall off here
          for (int b = 0; b < IMG_W; b++) begin
            if (b / CFG_W == int'(cnt_q)) img_d[b] = cfg_data[b % CFG_W];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SLICE_CONFIG_LOADER_CRC_EN
            state_d = CHECK;
`else
            state_d  = COMMIT;
            use_cc_d = img_d[IMG_W-1];
`endif
          end
        end
      end
`ifdef SLICE_CONFIG_LOADER_CRC_EN
      CHECK: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (xfer) begin
          if (cfg_data[7:0] == crc) begin
            state_d  = COMMIT;
            use_cc_d = img_q[IMG_W-1];
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ERROR: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
`endif
      COMMIT: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_q  <= IDLE;
      img_q    <= '0;
      cnt_q    <= '0;
      use_cc_q <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      ready_q  <= 1'b0;
`ifdef SLICE_CONFIG_LOADER_CRC_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      cnt_q    <= cnt_d;
      use_cc_q <= use_cc_d;
      done_q   <= done_d;
      en_q     <= (state_d == COMMIT);
      ready_q  <= (state_d == LOAD) || (state_d == CHECK);
`ifdef SLICE_CONFIG_LOADER_CRC_EN
      err_q    <= err_d;
`endif
    end
  end

  // a reset landing on the commit cycle must suppress the strobe at once
  assign config_en       = en_q && !config_rst;
  assign cfg_ready       = ready_q;
  assign cfg_done        = done_q;
  assign config_use_cc   = use_cc_q;
  assign luts_config_out = img_q[IMG_W-2:0];

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed and randomized bench for slice_config_loader.
// Build with SLICE_CONFIG_LOADER_CRC_EN defined to also cover the CRC path.
module tb_slice_config_loader;

  localparam int NW    = 18;
  localparam int IMG_W = 137;
  localparam int LW    = IMG_W - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          valid;
  logic [7:0]    data;
  logic          ready;
  logic [LW-1:0] luts;
  logic          use_cc;
  logic          en;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int e0 = 0;

  logic [7:0] w [NW];
  logic [IMG_W-1:0] exp_img;
  logic [IMG_W-1:0] prev_img;

`ifdef SLICE_CONFIG_LOADER_CRC_EN
  bit crc_flip = 1'b0;
`endif

  slice_config_loader dut (
    .config_clk      (clk),
    .config_rst      (rst),
    .cfg_start       (start),
    .cfg_data        (data),
    .cfg_valid       (valid),
    .cfg_ready       (ready),
    .luts_config_out (luts),
    .config_use_cc   (use_cc),
    .config_en       (en),
    .cfg_done        (done),
    .cfg_error       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (en) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // image = words concatenated, word 0 at the LSBs, padding dropped
  function automatic logic [IMG_W-1:0] model_img();
    logic [NW*8-1:0] wide;
    wide = '0;
    for (int k = NW - 1; k >= 0; k--) wide = (wide << 8) | (NW*8)'(w[k]);
    return wide[IMG_W-1:0];
  endfunction

`ifdef SLICE_CONFIG_LOADER_CRC_EN
  // bit-serial long division of the message by x^8+x^2+x+1
  function automatic logic [7:0] crc_model();
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int k = 0; k < NW; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ w[k][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction
`endif

  task automatic do_start();
    e0    = en_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, ready, 1'b1);
  endtask

  task automatic load_n(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        valid = 1'b0;
        repeat ($urandom_range(0, 3)) cyc();
      end
      valid = 1'b1;
      data  = w[k];
      wait_ready("load_ready");
      cyc();
    end
    valid = 1'b0;
  endtask

  task automatic tail();
`ifdef SLICE_CONFIG_LOADER_CRC_EN
    valid = 1'b1;
    data  = crc_model() ^ {7'b0, crc_flip};
    wait_ready("crc_ready");
    cyc();
    valid = 1'b0;
`endif
  endtask

  task automatic expect_commit(input string tag);
    exp_img = model_img();
    chk({tag, "_en_t1"}, en, 1'b1);
    chk({tag, "_done_t1"}, done, 1'b0);
    cyc();
    chk({tag, "_en_t2"}, en, 1'b0);
    chk({tag, "_done_t2"}, done, 1'b1);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_luts"}, luts, exp_img[LW-1:0]);
    chk({tag, "_cc"}, use_cc, exp_img[IMG_W-1]);
    chk({tag, "_pulses"}, en_cnt - e0, 1);
    prev_img = exp_img;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cc", use_cc, 1'b0);
    chk("rst_luts", luts, '0);

    // words offered in IDLE are not taken
    valid = 1'b1;
    data  = 8'h5A;
    repeat (3) cyc();
    chk("idle_ready", ready, 1'b0);
    chk("idle_luts", luts, '0);
    valid = 1'b0;

    // basic load 0x00..0x11
    for (int k = 0; k < NW; k++) w[k] = 8'(k);
    do_start();
    chk("load_ready0", ready, 1'b1);
    load_n(NW, 1'b0);
    tail();
    expect_commit("basic");
    chk("basic_b0", luts[7:0], 8'h00);
    chk("basic_b1", luts[15:8], 8'h01);
    chk("basic_cc1", use_cc, 1'b1);

    // words offered in DONE are not taken
    e0    = en_cnt;
    valid = 1'b1;
    data  = 8'hAA;
    repeat (3) cyc();
    chk("done_ready", ready, 1'b0);
    chk("done_hold", luts, prev_img[LW-1:0]);
    chk("done_noen", en_cnt - e0, 0);
    chk("done_still", done, 1'b1);
    valid = 1'b0;

    // same image with random bubbles
    do_start();
    chk("restart_done_clr", done, 1'b0);
    load_n(NW, 1'b1);
    tail();
    expect_commit("gaps");

    // random images with random bubbles
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
      do_start();
      load_n(NW, 1'b1);
      tail();
      expect_commit("rand");
    end

    // restart after 5 words, then an all-ones image
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
    do_start();
    load_n(5, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NW; k++) w[k] = 8'hFF;
    load_n(NW, 1'b0);
    tail();
    expect_commit("restart");
    chk("restart_ones", &luts, 1'b1);

    // restart coinciding with a transfer drops that word
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
    do_start();
    load_n(5, 1'b0);
    valid = 1'b1;
    data  = 8'h55;
    start = 1'b1;
    cyc();
    start = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
    load_n(NW, 1'b0);
    tail();
    expect_commit("collide");

    // reset after 17 words
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
    do_start();
    load_n(NW - 1, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_en", en, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_cc", use_cc, 1'b0);
    chk("mid_rst_luts", luts, '0);
    chk("mid_rst_err", err, 1'b0);
    valid = 1'b1;
    data  = w[NW-1];
    repeat (4) cyc();
    valid = 1'b0;
    chk("mid_rst_noen", en_cnt - e0, 0);
    chk("mid_rst_ready2", ready, 1'b0);

    // reset landing on the commit cycle
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom);
    do_start();
    load_n(NW, 1'b0);
    tail();
    rst = 1'b1;
    #1;
    chk("commit_rst_en", en, 1'b0);
    cyc();
    rst = 1'b0;
    chk("commit_rst_noen", en_cnt - e0, 0);
    chk("commit_rst_done", done, 1'b0);

`ifdef SLICE_CONFIG_LOADER_CRC_EN
    // good load first so use_cc is known to be 1
    for (int k = 0; k < NW; k++) w[k] = 8'(k);
    do_start();
    load_n(NW, 1'b0);
    tail();
    expect_commit("crc_ok");
    // corrupted CRC on an image whose use_cc bit is 0
    for (int k = 0; k < NW; k++) w[k] = 8'(k);
    w[NW-1] = 8'h10;
    crc_flip = 1'b1;
    do_start();
    load_n(NW, 1'b0);
    tail();
    crc_flip = 1'b0;
    cyc();
    chk("crc_bad_err", err, 1'b1);
    chk("crc_bad_noen", en_cnt - e0, 0);
    chk("crc_bad_cc", use_cc, 1'b1);
    chk("crc_bad_done", done, 1'b0);
    chk("crc_bad_ready", ready, 1'b0);
    do_start();
    chk("crc_err_clr", err, 1'b0);
    chk("crc_err_load", ready, 1'b1);
    load_n(NW, 1'b0);
    tail();
    expect_commit("crc_recover");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
